// File: rtl/qupls_regread_arbiter.sv
// Round-robin arbiter sharing NPORT register-file read ports among NREQ operand requesters.
// Optional build macro QUPLS_REGREAD_COALESCE_EN lets requesters that read the same register share one port.
module qupls_regread_arbiter #(
   parameter int NREQ  = 8,
   parameter int NPORT = 4,
   parameter int AREGW = 7,
   parameter int PIDW  = 2
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*AREGW-1:0]   regno_i,
   input  logic                    stall_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [NPORT-1:0]        port_v_o,
   output logic [NPORT*AREGW-1:0]  port_regno_o,
   output logic [NREQ*PIDW-1:0]    req_port_o,
   output logic [NREQ-1:0]         req_zero_o,
   output logic [15:0]             perf_conflict_o
);

   localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: requester k is served in any cycle where req_i[k] & gnt_o[k];
   // it must hold req_i[k] and its regno stable until that cycle.

   logic [RRW-1:0]         rr;
   logic [RRW-1:0]         rr_nxt;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        zero_nxt;
   logic [NPORT-1:0]       pv_nxt;
   logic [NPORT*AREGW-1:0] preg_nxt;
   logic [NREQ*PIDW-1:0]   rport_nxt;
   logic                   active;
   logic                   conflict;

   assign active = rst_n & ~stall_i;

   always_comb begin : scan
      int               k;
      int               used;
      int               hp;
      logic             hit;
      logic [AREGW-1:0] rg;
      gnt       = '0;
      zero_nxt  = '0;
      pv_nxt    = '0;
      preg_nxt  = '0;
      rport_nxt = '0;
      rr_nxt    = rr;
      used      = 0;
      k         = 0;
      hp        = 0;
      hit       = 1'b0;
      rg        = '0;
      for (int i = 0; i < NREQ; i++) begin
         k   = (int'(rr) + i) % NREQ;
         rg  = regno_i[k*AREGW +: AREGW];
         hit = 1'b0;
         hp  = 0;
`ifdef QUPLS_REGREAD_COALESCE_EN
         for (int p = 0; p < NPORT; p++) begin
            if (!hit && (p < used) && (preg_nxt[p*AREGW +: AREGW] == rg)) begin
               hit = 1'b1;
               hp  = p;
            end
         end
`endif
         if (active && req_i[RRW'(k)]) begin
            if (rg == '0) begin
               // Register 0 reads as zero, so no port is spent on it.
               gnt[RRW'(k)]      = 1'b1;
               zero_nxt[RRW'(k)] = 1'b1;
            end else if (hit) begin
               gnt[RRW'(k)]                = 1'b1;
               rport_nxt[k*PIDW +: PIDW]   = PIDW'(hp);
               rr_nxt                      = RRW'((k + 1) % NREQ);
            end else if (used < NPORT) begin
               gnt[RRW'(k)]                = 1'b1;
               rport_nxt[k*PIDW +: PIDW]   = PIDW'(used);
               pv_nxt[PIDW'(used)]         = 1'b1;
               preg_nxt[used*AREGW +: AREGW] = rg;
               rr_nxt                      = RRW'((k + 1) % NREQ);
               used                        = used + 1;
            end
         end
      end
      conflict = |(req_i & ~gnt);
   end

   assign gnt_o = gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr              <= '0;
         port_v_o        <= '0;
         port_regno_o    <= '0;
         req_port_o      <= '0;
         req_zero_o      <= '0;
         perf_conflict_o <= '0;
      end else begin
         if (!stall_i) begin
            rr           <= rr_nxt;
            port_v_o     <= pv_nxt;
            port_regno_o <= preg_nxt;
            req_port_o   <= rport_nxt;
            req_zero_o   <= zero_nxt;
         end
         // Conflicts are counted even while stalled.
         if (conflict && (perf_conflict_o != 16'hFFFF))
            perf_conflict_o <= perf_conflict_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_qupls_regread_arbiter.sv
// Self-checking bench for qupls_regread_arbiter: directed table, stall/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_qupls_regread_arbiter;

   localparam int NREQ  = 8;
   localparam int NPORT = 4;
   localparam int AREGW = 7;
   localparam int PIDW  = 2;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [7:0]  req;
   logic [55:0] regno;
   logic [7:0]  gnt_o;
   logic [3:0]  port_v_o;
   logic [27:0] port_regno_o;
   logic [15:0] req_port_o;
   logic [7:0]  req_zero_o;
   logic [15:0] perf_conflict_o;

   qupls_regread_arbiter #(
      .NREQ(NREQ), .NPORT(NPORT), .AREGW(AREGW), .PIDW(PIDW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_i(req),
      .regno_i(regno),
      .stall_i(stall),
      .gnt_o(gnt_o),
      .port_v_o(port_v_o),
      .port_regno_o(port_regno_o),
      .req_port_o(req_port_o),
      .req_zero_o(req_zero_o),
      .perf_conflict_o(perf_conflict_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // reference model state
   int          m_rr;
   logic [3:0]  m_pv;
   logic [27:0] m_preg;
   logic [15:0] m_rport;
   logic [7:0]  m_zero;
   logic [15:0] m_perf;

   logic [7:0]  e_g;
   logic [7:0]  e_zero;
   logic [6:0]  e_taken[$];
   int          e_port[8];
   int          e_rr;
   logic [7:0]  gnt_snap;

   typedef struct packed {
      logic [7:0]  req;
      logic [55:0] regs;
      logic        stall;
      logic [7:0]  gnt;
      logic [3:0]  pv;
   } vec_t;

   vec_t tab[8];

   function automatic logic [55:0] pk_seq(input int base, input int step);
      logic [55:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*7 +: 7] = 7'(base + k*step);
      return r;
   endfunction

   function automatic logic [55:0] pk2(input int a0, input int a1);
      logic [55:0] r;
      r = '0;
      r[6:0]  = 7'(a0);
      r[13:7] = 7'(a1);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_pv = '0; m_preg = '0; m_rport = '0; m_zero = '0; m_perf = '0;
   endtask

   // Grants follow the scan order from rr; ports are a queue of taken regnos.
   task automatic model_eval();
      e_g = '0; e_zero = '0; e_taken.delete(); e_rr = m_rr;
      for (int i = 0; i < 8; i++) e_port[i] = 0;
      if (rst_n && !stall) begin
         for (int i = 0; i < 8; i++) begin
            int k;
            int found;
            logic [6:0] r;
            k = (m_rr + i) % 8;
            r = regno[k*7 +: 7];
            found = -1;
            if (req[k]) begin
               if (r == 7'd0) begin
                  e_g[k] = 1'b1;
                  e_zero[k] = 1'b1;
               end else begin
`ifdef QUPLS_REGREAD_COALESCE_EN
                  foreach (e_taken[j]) if (found < 0 && e_taken[j] == r) found = j;
`endif
                  if (found >= 0) begin
                     e_g[k] = 1'b1; e_port[k] = found; e_rr = (k + 1) % 8;
                  end else if (e_taken.size() < NPORT) begin
                     e_g[k] = 1'b1; e_port[k] = e_taken.size();
                     e_taken.push_back(r); e_rr = (k + 1) % 8;
                  end
               end
            end
         end
      end
   endtask

   task automatic model_commit();
      if (|(req & ~e_g) && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
      if (!stall) begin
         m_pv = '0; m_preg = '0; m_rport = '0;
         for (int p = 0; p < e_taken.size(); p++) begin
            m_pv[p] = 1'b1;
            m_preg[p*7 +: 7] = e_taken[p];
         end
         for (int k = 0; k < 8; k++) if (e_g[k]) m_rport[k*2 +: 2] = 2'(e_port[k]);
         m_zero = e_zero;
         m_rr = e_rr;
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_port_v"}, port_v_o, m_pv);
      chk({tag, "_port_regno"}, port_regno_o, m_preg);
      chk({tag, "_req_port"}, req_port_o, m_rport);
      chk({tag, "_req_zero"}, req_zero_o, m_zero);
      chk({tag, "_perf"}, perf_conflict_o, m_perf);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt_o, 8'h00);
      chk({tag, "_port_v"}, port_v_o, 4'h0);
      chk({tag, "_port_regno"}, port_regno_o, 28'h0);
      chk({tag, "_req_port"}, req_port_o, 16'h0);
      chk({tag, "_req_zero"}, req_zero_o, 8'h00);
      chk({tag, "_perf"}, perf_conflict_o, 16'h0);
   endtask

   // driver: inputs are set just after a rising edge; one clock is consumed
   task automatic do_cycle(input string tag);
      #3;
      model_eval();
      chk({tag, "_gnt"}, gnt_o, e_g);
      gnt_snap = gnt_o;
      @(posedge clk);
      model_commit();
      #1;
      check_regs(tag);
   endtask

   logic [7:0] pend;
   int         wait_cnt[8];
   logic [15:0] perf_base;

   initial begin
      n_cmp = 0; n_err = 0;
      model_reset();
      rst_n = 1'b0; stall = 1'b0; req = 8'hFF; regno = pk_seq(1, 1);
      #2;
      check_all_zero("reset");
      req = 8'h00;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      tab[0] = '{req:8'h0F, regs:pk_seq(5, 1), stall:1'b0, gnt:8'h0F, pv:4'hF};
      tab[1] = '{req:8'hFF, regs:pk_seq(1, 1), stall:1'b0, gnt:8'hF0, pv:4'hF};
      tab[2] = '{req:8'hFF, regs:pk_seq(1, 1), stall:1'b0, gnt:8'h0F, pv:4'hF};
      tab[3] = '{req:8'h03, regs:pk2(0, 64),   stall:1'b0, gnt:8'h03, pv:4'h1};
      tab[4] = '{req:8'h00, regs:'0,           stall:1'b0, gnt:8'h00, pv:4'h0};
      tab[5] = '{req:8'h01, regs:pk2(5, 0),    stall:1'b1, gnt:8'h00, pv:4'h0};
      tab[6] = '{req:8'h01, regs:pk2(5, 0),    stall:1'b0, gnt:8'h01, pv:4'h1};
`ifdef QUPLS_REGREAD_COALESCE_EN
      tab[7] = '{req:8'hFF, regs:pk_seq(9, 0), stall:1'b0, gnt:8'hFF, pv:4'h1};
`else
      tab[7] = '{req:8'hFF, regs:pk_seq(9, 0), stall:1'b0, gnt:8'h1E, pv:4'hF};
`endif
      for (int i = 0; i < 8; i++) begin
         req = tab[i].req; regno = tab[i].regs; stall = tab[i].stall;
         do_cycle("tab");
         chk($sformatf("tab%0d_gnt_const", i), gnt_snap, tab[i].gnt);
         chk($sformatf("tab%0d_pv_const", i), port_v_o, tab[i].pv);
      end

      // stall for three cycles, then release
      req = 8'h01; regno = pk2(5, 0); stall = 1'b1;
      perf_base = m_perf;
      repeat (3) do_cycle("stall");
      chk("stall_perf_delta", perf_conflict_o, perf_base + 16'd3);
      stall = 1'b0;
      do_cycle("release");
      chk("release_gnt", gnt_snap, 8'h01);

      // randomized traffic; requesters hold until granted
      pend = '0;
      for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 8; k++) begin
            if (!pend[k] && $urandom_range(0, 1) == 1) begin
               pend[k] = 1'b1;
               wait_cnt[k] = 0;
               if ($urandom_range(0, 3) == 0) regno[k*7 +: 7] = 7'd0;
               else regno[k*7 +: 7] = 7'($urandom_range(1, 6)) |
                                      (($urandom_range(0, 1) == 1) ? 7'h40 : 7'h00);
            end
         end
         req = pend;
         stall = ($urandom_range(0, 4) == 0);
         do_cycle("rand");
         for (int k = 0; k < 8; k++) begin
            if (pend[k]) begin
               if (!stall) wait_cnt[k]++;
               if (gnt_snap[k]) begin
                  chk($sformatf("wait_bound_req%0d", k), 64'(wait_cnt[k] <= 2), 64'd1);
                  pend[k] = 1'b0;
               end
            end
         end
      end

      // asynchronous reset in the middle of traffic
      stall = 1'b0; req = 8'h01; regno = pk2(5, 0);
      do_cycle("pre_rst");
      req = 8'hFF; regno = pk_seq(1, 1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      model_reset();
      req = 8'h00;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      req = 8'hFF; regno = pk_seq(1, 1);
      do_cycle("restart");
      chk("restart_gnt", gnt_snap, 8'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
